// File: rtl/sd_block_responder.sv
// sd_block_responder: services 512-byte SD sector reads/writes against a byte-addressed
// image store and reports image mounts to the core.
module sd_block_responder #(
  parameter int SECTOR_BYTES = 512
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  input  logic        mount_req,
  input  logic [63:0] mount_size,
  input  logic        mount_ro,
  output logic        img_mounted,
  output logic [63:0] img_size,
  output logic        img_readonly,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_MEM, WR_WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [22:0] lba;
  logic [7:0]  wdata;
  logic        in_range, wr_ok;
  logic [63:0] sector_end;
  logic        range_ok, accept, last, rd_go, wr_go;
  assign sector_end = ({32'd0, sd_lba} + 64'd1) << 9;
  assign range_ok   = sector_end <= img_size;
  assign accept     = (state == IDLE) && (sd_rd || sd_wr);
  assign last       = sd_buff_addr == 9'(SECTOR_BYTES - 1);
  assign rd_go      = (state == RD_WAIT) && (mem_ready || !in_range);
  assign wr_go      = (state == WR_WAIT) && (mem_ready || !wr_ok);
  assign sd_ack     = (state != IDLE) && (state != DONE);
  assign sd_buff_wr = state == RD_PUT;
  assign mem_rd     = (state == RD_REQ) && in_range;
  assign mem_wr     = (state == WR_MEM) && wr_ok;
  // The store samples write data in the same cycle as the mem_wr pulse.
  assign mem_wdata  = (state == WR_MEM) ? sd_buff_din : wdata;
  assign mem_addr   = {lba, sd_buff_addr};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = sd_rd ? RD_REQ : sd_wr ? WR_ADDR : IDLE;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: state_nx = rd_go ? RD_PUT : RD_WAIT;
      RD_PUT:  state_nx = last ? DONE : RD_REQ;
      WR_ADDR: state_nx = WR_MEM;
      WR_MEM:  state_nx = WR_WAIT;
      WR_WAIT: state_nx = wr_go ? (last ? DONE : WR_ADDR) : WR_WAIT;
      DONE:    state_nx = (sd_rd || sd_wr) ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // The range/read-only decision is frozen at accept so a mid-transfer mount cannot change it.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      lba          <= '0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      wdata        <= '0;
      in_range     <= 1'b0;
      wr_ok        <= 1'b0;
      img_mounted  <= 1'b0;
      img_size     <= '0;
      img_readonly <= 1'b0;
    end else begin
      img_mounted <= mount_req;
      if (mount_req) begin
        img_size     <= mount_size;
        img_readonly <= mount_ro;
      end
      if (accept) begin
        lba          <= sd_lba[22:0];
        sd_buff_addr <= '0;
        in_range     <= range_ok;
        wr_ok        <= range_ok && !img_readonly;
      end
      if (rd_go) sd_buff_dout <= in_range ? mem_rdata : 8'h00;
      if (state == WR_MEM) wdata <= sd_buff_din;
      if ((state == RD_PUT || wr_go) && !last) sd_buff_addr <= sd_buff_addr + 9'd1;
    end
endmodule
